// File: rtl/divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding,
// default operand width and the iteration-counter sizing rule.
package divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  // Counter must hold WIDTH-1 plus one spare bit so the step index never wraps.
  function automatic int div_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration on unsigned magnitudes: shift {rem, quo}
// left, subtract the divisor if it fits and record the quotient bit.
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  assign rem_sh = {rem, quo[WIDTH-1]};

  // rem < divisor keeps the difference inside WIDTH+1 bits, so the MSB is its sign.
  assign trial    = rem_sh - {1'b0, divisor};
  assign rem_next = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/divider.sv
// Sequential signed divider for the DIV instruction: WIDTH restoring steps
// on magnitudes, then a sign-fix cycle; divide-by-zero is flagged at start.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] high,
  output logic [WIDTH-1:0] low,
  output logic             div_end,
  output logic             div_zero,
  output logic             busy
);

  localparam int CNT_W = div_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e state, state_next;

  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [CNT_W-1:0] cnt;
  logic             qneg, rneg;
  logic             b_zero;
  logic             load_op, step_en, fix_en, zero_hit;

  assign b_zero = (b == '0);
  // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
  assign a_mag  = a[WIDTH-1] ? -a : a;
  assign b_mag  = b[WIDTH-1] ? -b : b;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= DIV_IDLE;
    else        state <= state_next;
  end

  // NOTE: each combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (div && !b_zero)   state_next = DIV_RUN;
      DIV_RUN:  if (cnt == LAST_STEP) state_next = DIV_FIX;
      DIV_FIX:                        state_next = DIV_IDLE;
      default:                        state_next = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    load_op  = 1'b0;
    step_en  = 1'b0;
    fix_en   = 1'b0;
    zero_hit = 1'b0;
    case (state)
      DIV_IDLE: begin
        load_op  = div && !b_zero;
        zero_hit = div && b_zero;
      end
      DIV_RUN: begin
        busy    = 1'b1;
        step_en = 1'b1;
      end
      DIV_FIX: begin
        busy   = 1'b1;
        fix_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
    end else if (load_op) begin
      rem  <= '0;
      quo  <= a_mag;
      dvs  <= b_mag;
      cnt  <= '0;
      qneg <= a[WIDTH-1] ^ b[WIDTH-1];
      rneg <= a[WIDTH-1];
    end else if (step_en) begin
      rem  <= rem_step;
      quo  <= quo_step;
      cnt  <= cnt + 1'b1;
    end
  end

  // Results only move in FIX, so they hold the previous answer through RUN
  // and across a divide-by-zero request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      high     <= '0;
      low      <= '0;
      div_end  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      div_end  <= fix_en;
      div_zero <= zero_hit;
      if (fix_en) begin
        low  <= qneg ? -quo : quo;
        high <= rneg ? -rem : rem;
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases from the block's rules plus
// randomized back-to-back divisions checked against a 64-bit arithmetic model.
module tb_divider;

  localparam int W       = 32;
  localparam int LATENCY = 33;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         div = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] high, low;
  logic         div_end, div_zero, busy;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_low  = '0;
  logic [W-1:0] exp_high = '0;

  divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .div      (div),
    .a        (a),
    .b        (b),
    .high     (high),
    .low      (low),
    .div_end  (div_end),
    .div_zero (div_zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  // Reference: signed 64-bit arithmetic truncates toward zero and gives the
  // remainder the dividend's sign; truncation to 32 bits yields the overflow wrap.
  function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q  = W'(sx / sy);
    r  = W'(sx % sy);
  endfunction

  always @(negedge clk) check("excl", {63'b0, div_end & div_zero}, 64'd0);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge E0.
  task automatic start(input logic [W-1:0] x, input logic [W-1:0] y);
    div = 1'b1;
    a   = x;
    b   = y;
    tick();
    div = 1'b0;
  endtask

  // n0 = number of edges already elapsed since E0; waits for div_end with a bound.
  task automatic wait_done(input string tag, input int n0,
                           input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] q, r;
    int n;
    ref_div(x, y, q, r);
    n = n0;
    while (!div_end && n < LATENCY + 8) begin
      if (n == 16) begin
        check({tag, "/hold"}, {32'b0, high, low}, {32'b0, exp_high, exp_low});
        check({tag, "/busy"}, {63'b0, busy}, 64'd1);
      end
      tick();
      n++;
    end
    check({tag, "/latency"}, 64'(n), 64'(LATENCY));
    check({tag, "/low"},  {32'b0, low},  {32'b0, q});
    check({tag, "/high"}, {32'b0, high}, {32'b0, r});
    exp_low  = q;
    exp_high = r;
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    start(x, y);
    if (y == '0) begin
      check({tag, "/dz"},    {63'b0, div_zero}, 64'd1);
      check({tag, "/dzbusy"}, {63'b0, busy},    64'd0);
      check({tag, "/dzlow"},  {32'b0, low},     {32'b0, exp_low});
      check({tag, "/dzhigh"}, {32'b0, high},    {32'b0, exp_high});
      tick();
      check({tag, "/dzpulse"}, {63'b0, div_zero}, 64'd0);
      check({tag, "/dzend"},   {63'b0, div_end},  64'd0);
      check({tag, "/dzidle"},  {63'b0, busy},     64'd0);
    end else begin
      check({tag, "/busy0"}, {63'b0, busy},     64'd1);
      check({tag, "/nodz"},  {63'b0, div_zero}, 64'd0);
      wait_done(tag, 0, x, y);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/high"},  {32'b0, high},     64'd0);
    check({tag, "/low"},   {32'b0, low},      64'd0);
    check({tag, "/end"},   {63'b0, div_end},  64'd0);
    check({tag, "/dz"},    {63'b0, div_zero}, 64'd0);
    check({tag, "/busy"},  {63'b0, busy},     64'd0);
  endtask

  function automatic logic [W-1:0] rand_operand(input bit divisor);
    logic [W-1:0] v;
    int sel;
    sel = int'($urandom_range(0, 9));
    v   = $urandom;
    case (sel)
      0: v = divisor ? '0 : 32'h8000_0000;
      1: v = ($urandom_range(0, 1) != 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
      2: v = W'($signed(int'($urandom_range(0, 200)) - 100));
      3: v = 32'h8000_0000;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    int n;
    logic [W-1:0] ra, rb;

    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b1;
    @(negedge clk);

    run_div("7/2",   32'd7,          32'd2);
    run_div("-7/2",  32'hFFFF_FFF9,  32'd2);
    run_div("7/-2",  32'd7,          32'hFFFF_FFFE);
    run_div("pre",   32'd7,          32'd2);
    run_div("7/0",   32'd7,          32'd0);
    repeat (5) begin
      tick();
      check("dz_quiet", {63'b0, div_end}, 64'd0);
    end
    check("dz_keep", {32'b0, high, low}, {32'b0, 32'd1, 32'd3});

    run_div("ovf",   32'h8000_0000,  32'hFFFF_FFFF);
    run_div("5/9",   32'd5,          32'd9);

    // A second start mid-run must be ignored without disturbing the operands.
    start(32'd100, 32'd7);
    for (int i = 1; i < 10; i++) tick();
    check("e10/hold", {32'b0, high, low}, {32'b0, exp_high, exp_low});
    start(32'd1, 32'd1);
    wait_done("e10", 10, 32'd100, 32'd7);
    check("e10/q", {32'b0, low}, 64'd14);
    n = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (div_end) n++;
    end
    check("e10/single", 64'(n), 64'd0);

    // Reset mid-run discards the operation.
    start(32'd100, 32'd7);
    for (int i = 1; i < 12; i++) tick();
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    tick();
    reset = 1'b1;
    check_all_zero("rst_rel");
    exp_low  = '0;
    exp_high = '0;
    run_div("9/3", 32'd9, 32'd3);

    // Randomized, issued back to back in the cycle div_end is high.
    for (int i = 0; i < 200; i++) begin
      ra = rand_operand(1'b0);
      rb = rand_operand(1'b1);
      run_div("rnd", ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
